cache_req_master: RTL and testbench

- Upstream neighbour of the generic cache: accepts a simple valid/ready command stream and issues each command on the cache's master-side 4-phase request/valid handshake.
- Buffers commands in a small FIFO and runs one handshake at a time.
- Returns each completion (with read data) as a one-cycle response pulse.
- Sits between the trace/CPU model and the cache slave.

---
 rtl/cachepkg.sv | 26 ++
 rtl/cache_cmd_fifo.sv | 56 +++++
 rtl/cache_req_master.sv | 164 ++++++++++++++++
 tb/tb_cache_req_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepkg.sv
// Shared cache types: the operation encoding, requester FSM states and the write-op decode.
`default_nettype none

package cachepkg;

  typedef enum logic [3:0] {
    INST_NOP   = 4'h0,
    INST_READ  = 4'h1,
    INST_WRITE = 4'h2
  } inst_t;

  localparam int OP_W = $bits(inst_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } req_state_t;

  function automatic logic is_write(input inst_t op);
    return op == INST_WRITE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_cmd_fifo.sv
// Command FIFO: registered occupancy count, no empty bypass, pointers wrap modulo DEPTH.
`default_nettype none

module cache_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 44
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/cache_req_master.sv
// Buffers valid/ready commands and replays each on the cache 4-phase request/valid handshake.
// Optional watchdog enabled by defining CACHE_REQ_TIMEOUT_EN.
`default_nettype none

module cache_req_master
  import cachepkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  inst_t             cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output inst_t             rsp_op,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output inst_t             cache_operation,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data_o,
  output logic              cache_data_oe,
  input  logic [DATA_W-1:0] cache_data_i,
  output logic              cache_request,
  input  logic              cache_valid,
  output logic              timeout
);

  localparam int PAYLOAD_W = OP_W + ADDR_W + DATA_W;

  req_state_t        state_q, state_d;
  inst_t             op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_en_q;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [PAYLOAD_W-1:0] fifo_rdata;

`ifdef CACHE_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // ready_en_q holds cmd_ready low while reset is asserted.
  assign cmd_ready = ready_en_q && !fifo_full;

  cache_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_op, cmd_addr, cmd_wdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    fifo_pop    = 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
    cnt_d       = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    timeout_d   = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = inst_t'(fifo_rdata[PAYLOAD_W-1 -: OP_W]);
          addr_d   = fifo_rdata[DATA_W +: ADDR_W];
          wdata_d  = fifo_rdata[DATA_W-1:0];
          state_d  = REQ;
        end
      end
      REQ: begin
        if (cache_valid) begin
          rdata_d     = is_write(op_q) ? '0 : cache_data_i;
          rsp_valid_d = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!cache_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef CACHE_REQ_TIMEOUT_EN
    // Watchdog abort; a RELEASE-phase abort already reported its response.
    if (state_q != IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
      if (state_q == REQ) begin
        rsp_valid_d = 1'b1;
        rdata_d     = '0;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= INST_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_en_q  <= 1'b1;
    end
  end

`ifdef CACHE_REQ_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  // Without the watchdog the limit has no effect and the flag is constant low.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign cache_request   = (state_q == REQ);
  assign cache_operation = op_q;
  assign cache_addr      = addr_q;
  assign cache_data_o    = wdata_q;
  assign cache_data_oe   = cache_request && is_write(op_q);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_op          = op_q;
  assign rsp_addr        = addr_q;
  assign rsp_rdata       = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_req_master.sv
// Directed bench for cache_req_master: table of single transactions plus multi-cycle corner sequences.
`default_nettype none

module tb_cache_req_master;
  import cachepkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  inst_t       cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  inst_t       rsp_op;
  logic [31:0] rsp_addr;
  logic [7:0]  rsp_rdata;
  inst_t       cache_operation;
  logic [31:0] cache_addr;
  logic [7:0]  cache_data_o;
  logic        cache_data_oe;
  logic [7:0]  cache_data_i;
  logic        cache_request;
  logic        cache_valid;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cache_req_master #(
    .ADDR_W(32), .DATA_W(8), .DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .cache_operation(cache_operation), .cache_addr(cache_addr),
    .cache_data_o(cache_data_o), .cache_data_oe(cache_data_oe),
    .cache_data_i(cache_data_i), .cache_request(cache_request),
    .cache_valid(cache_valid), .timeout(timeout)
  );

  typedef struct {
    inst_t       op;
    logic [31:0] addr;
    logic [7:0]  wdata;
    int          delay;      // cycles request stays up before the slave acks
    logic [7:0]  sdata;      // value the slave drives on cache_data_i
    logic [7:0]  exp_rdata;
    logic        exp_oe;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!cache_request && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!cache_request) begin
      fails++;
      $display("FAIL wait_req: request not seen within %0d cycles", n);
    end
  endtask

  task automatic push(input inst_t op, input logic [31:0] addr, input logic [7:0] wd);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata;
    check("txn_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("txn_req_c1", cache_request, 0);
    tick();
    check("txn_req_c2", cache_request, 1);
    check("txn_addr", cache_addr, v.addr);
    check("txn_op", cache_operation, v.op);
    check("txn_data_o", cache_data_o, v.wdata);
    check("txn_oe", cache_data_oe, v.exp_oe);
    for (int i = 0; i < v.delay; i++) begin
      tick();
      check("txn_hold_req", cache_request, 1);
      check("txn_hold_oe", cache_data_oe, v.exp_oe);
      check("txn_hold_addr", cache_addr, v.addr);
      check("txn_hold_norsp", rsp_valid, 0);
    end
    cache_valid = 1'b1; cache_data_i = v.sdata;
    tick();
    cache_valid = 1'b0; cache_data_i = 8'h00;
    check("txn_rsp_valid", rsp_valid, 1);
    check("txn_rsp_rdata", rsp_rdata, v.exp_rdata);
    check("txn_rsp_addr", rsp_addr, v.addr);
    check("txn_rsp_op", rsp_op, v.op);
    check("txn_rel_req", cache_request, 0);
    check("txn_rel_oe", cache_data_oe, 0);
    tick();
    check("txn_rsp_pulse", rsp_valid, 0);
    check("txn_idle_req", cache_request, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int n;
    vecs[0] = '{INST_READ,  32'h0000_0040, 8'h00, 3, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{INST_WRITE, 32'h0000_0010, 8'h3C, 0, 8'h77, 8'h00, 1'b1};
    vecs[2] = '{INST_READ,  32'hFFFF_FFFF, 8'h11, 0, 8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{INST_WRITE, 32'h8000_0000, 8'hC3, 2, 8'h5A, 8'h00, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = INST_NOP; cmd_addr = '0; cmd_wdata = '0;
    cache_data_i = '0; cache_valid = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_request", cache_request, 0);
    check("rst_addr", cache_addr, 0);
    check("rst_oe", cache_data_oe, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // cache_valid while idle must be ignored
    cache_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(rsp_valid);
      check("idle_valid_noreq", cache_request, 0);
    end
    cache_valid = 1'b0;
    tick();
    check("idle_valid_norsp", pulses, 0);

    // Five back-to-back commands with a stalled slave
    for (int i = 0; i < 5; i++) begin
      check("b2b_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = INST_READ; cmd_addr = 32'h100 + 32'(i); cmd_wdata = '0;
      tick();
    end
    cmd_valid = 1'b0;
    check("b2b_full", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      wait_req();
      check("b2b_req_addr", cache_addr, 32'h100 + 32'(i));
      cache_valid = 1'b1; cache_data_i = 8'(8'h20 + i);
      tick();
      cache_valid = 1'b0;
      check("b2b_rsp_valid", rsp_valid, 1);
      check("b2b_rsp_addr", rsp_addr, 32'h100 + 32'(i));
      check("b2b_rsp_rdata", rsp_rdata, 8'h20 + 8'(i));
      tick();
    end
    check("b2b_ready_again", cmd_ready, 1);

    // Slave keeps valid high long after request drops
    push(INST_READ, 32'h20, 8'h00);
    tick();
    check("hold_req_up", cache_request, 1);
    cache_valid = 1'b1; cache_data_i = 8'h5A;
    tick();
    pulses = int'(rsp_valid);
    check("hold_rsp_rdata", rsp_rdata, 8'h5A);
    push(INST_READ, 32'h24, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check("hold_no_req", cache_request, 0);
      pulses += int'(rsp_valid);
      tick();
    end
    check("hold_no_req_last", cache_request, 0);
    pulses += int'(rsp_valid);
    check("hold_one_rsp", pulses, 1);
    cache_valid = 1'b0;
    tick();
    check("hold_release_noreq", cache_request, 0);
    wait_req();
    check("hold_second_addr", cache_addr, 32'h24);
    cache_valid = 1'b1;
    tick();
    cache_valid = 1'b0;
    check("hold_second_rsp", rsp_valid, 1);
    tick();

    // Reset in the middle of a handshake, with a second command queued
    push(INST_READ, 32'h30, 8'h00);
    push(INST_WRITE, 32'h34, 8'h99);
    check("mid_rst_req_up", cache_request, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_req_drop", cache_request, 0);
    check("mid_rst_norsp", rsp_valid, 0);
    reset = 1'b0;
    pulses = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += int'(rsp_valid);
      n += int'(cache_request);
    end
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_fifo_empty", n, 0);
    check("mid_rst_no_rsp", pulses, 0);

    // Slave never acks
    push(INST_READ, 32'h50, 8'h00);
    tick();
    n = 0;
    while (cache_request && n < 40) begin
      n++;
      tick();
    end
`ifdef CACHE_REQ_TIMEOUT_EN
    check("to_req_cycles", n, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_flag", timeout, 1);
    tick(); tick(); tick();
    check("to_sticky", timeout, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("to_cleared", timeout, 0);
`else
    check("nto_still_waiting", n, 40);
    check("nto_flag", timeout, 0);
    cache_valid = 1'b1;
    tick();
    cache_valid = 1'b0;
    check("nto_late_rsp", rsp_valid, 1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
